// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle behind a start/busy/done handshake.
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [N-1:0]  rem, q, dvsr;
  logic [CW-1:0] cnt;
  logic          qneg, rneg, is_rem;

  logic          sgn;
  logic [N-1:0]  a_mag, b_mag;
  logic [N:0]    trial;
  logic [N-1:0]  rem_nx, q_nx;

  always_comb begin
    sgn   = ~op[0];
    a_mag = (sgn && dividend[N-1]) ? -dividend : dividend;
    b_mag = (sgn && divisor[N-1])  ? -divisor  : divisor;
    // Trial subtract as add of the inverted divisor with carry-in 1.
    trial = {rem, q[N-1]} + {1'b1, ~dvsr} + {{N{1'b0}}, 1'b1};
    if (!trial[N]) begin
      rem_nx = trial[N-1:0];
      q_nx   = {q[N-2:0], 1'b1};
    end else begin
      rem_nx = {rem[N-2:0], q[N-1]};
      q_nx   = {q[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy   <= 1'b1;
            is_rem <= op[1];
            dvsr   <= b_mag;
            cnt    <= '0;
            if (divisor == '0) begin
              // Divide by zero: all-ones quotient, untouched dividend as remainder.
              q      <= '1;
              rem    <= dividend;
              qneg   <= 1'b0;
              rneg   <= 1'b0;
              result <= op[1] ? dividend : '1;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              q     <= a_mag;
              rem   <= '0;
              qneg  <= sgn & (dividend[N-1] ^ divisor[N-1]);
              rneg  <= sgn & dividend[N-1];
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          q   <= q_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N-1)) begin
            // Sign fix-up folded into the last iteration so result is valid with done.
            result <= is_rem ? (rneg ? -rem_nx : rem_nx)
                             : (qneg ? -q_nx   : q_nx);
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed ops push expectations,
// a negedge monitor checks result, latency and busy span on each done.
module tb_seq_divider;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done;
  logic [31:0] result;

  seq_divider #(.N(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          t0;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nfail = 0;
  int   brun = 0;
  bit   chk_idle = 1'b0;
  bit   tmo_req = 1'b0;
  bit   fin_req = 1'b0;
  string tmo_name = "";

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    brun = busy ? brun + 1 : 0;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
        chk({e.name, "_busy_span"}, 32'(brun), 32'(e.lat));
      end
    end
    if (chk_idle) begin
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_result", result, 32'd0);
    end
    if (tmo_req) chk({"timeout_", tmo_name}, 32'd1, 32'd0);
    if (fin_req) chk("scoreboard_empty", 32'(sb.size()), 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    if (busy) begin
      tmo_name = name;
      tmo_req  = 1'b1;
      step();
      tmo_req  = 1'b0;
    end
  endtask

  task automatic issue(string name, logic [1:0] o, logic [31:0] a, logic [31:0] b);
    step();
    start = 1'b1; op = o; dividend = a; divisor = b;
  endtask

  task automatic accept_and_scramble();
    step();
    start = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    op       = 2'($urandom);
  endtask

  task automatic do_op(string name, logic [1:0] o, logic [31:0] a, logic [31:0] b,
                       logic [31:0] exp);
    issue(name, o, a, b);
    sb.push_back('{res: exp, t0: cyc, lat: (b == 0) ? 1 : 33, name: name});
    accept_and_scramble();
    wait_idle(name);
  endtask

  initial begin
    int s;
    // Reset held: outputs quiet
    rst = 1'b0;
    step(); step();
    chk_idle = 1'b1;
    step();
    chk_idle = 1'b0;
    rst = 1'b1;

    do_op("divu_100_7",   DIVU, 32'd100,        32'd7,          32'd14);
    do_op("remu_100_7",   REMU, 32'd100,        32'd7,          32'd2);
    do_op("div_m7_2",     DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
    do_op("rem_m7_2",     REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
    do_op("rem_7_m2",     REM,  32'd7,          32'hFFFF_FFFE,  32'd1);
    do_op("div_7_m2",     DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD);
    do_op("divu_f9_2",    DIVU, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC);
    do_op("divu_5_0",     DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF);
    do_op("rem_m7_0",     REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9);
    do_op("div_m7_0",     DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF);
    do_op("div_ovf",      DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
    do_op("rem_ovf",      REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
    do_op("divu_max_1",   DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF);
    do_op("remu_max_64k", REMU, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF);

    // Start while busy is ignored
    issue("busy_ignore", DIVU, 32'd100, 32'd7);
    s = cyc;
    sb.push_back('{res: 32'd14, t0: s, lat: 33, name: "busy_ignore"});
    accept_and_scramble();
    while (cyc < s + 10) step();
    start = 1'b1; op = DIVU; dividend = 32'd9; divisor = 32'd3;
    step();
    start = 1'b0;
    wait_idle("busy_ignore");
    repeat (5) step();
    do_op("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3);

    // Reset mid-operation aborts with no done
    issue("rst_abort", DIVU, 32'd1000, 32'd3);
    s = cyc;
    accept_and_scramble();
    while (cyc < s + 10) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_idle = 1'b1;
    step();
    chk_idle = 1'b0;
    repeat (50) step();
    do_op("divu_1000_3", DIVU, 32'd1000, 32'd3, 32'd333);

    fin_req = 1'b1;
    step();
    fin_req = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
